// File: rtl/tdm_demux1_4_4bit.sv
// Receive-side TDM demultiplexer: splits a 4-slot framed word stream back into
// four registered lanes A..D, pulses FrameValid per complete frame and err on
// framing faults or mid-frame stalls, then re-hunts for the next sync word.
module tdm_demux1_4_4bit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 16   // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    input  logic             InValid,
    input  logic             Sync,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [WIDTH-1:0] OutC,
    output logic [WIDTH-1:0] OutD,
    output logic             FrameValid,
    output logic [1:0]       Slot,
    output logic             err
);

    typedef enum logic [0:0] {StHunt, StRun} state_e;

    // Idle-cycle limit widened by one bit so the incremented count never wraps.
    localparam logic [8:0] GapLim = 9'(GAP);

    state_e           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [7:0]       gap_q, gap_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] sh2_q, sh2_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic [WIDTH-1:0] out_d_q, out_d_d;
    logic             frame_valid_q, frame_valid_d;
    logic             err_q, err_d;

    logic [8:0]       gap_inc;

    assign gap_inc = {1'b0, gap_q} + 9'd1;

    // Next-state logic: framing FSM, slot capture, gap timeout and frame output.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        gap_d         = gap_q;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        sh2_d         = sh2_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_c_d       = out_c_q;
        out_d_d       = out_d_q;
        frame_valid_d = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            StHunt: begin
                slot_d = 2'd0;
                gap_d  = 8'd0;
                // Unsynced words are silently discarded while hunting.
                if (InValid && Sync) begin
                    sh0_d   = In;
                    slot_d  = 2'd1;
                    state_d = StRun;
                end
            end

            StRun: begin
                if (InValid) begin
                    gap_d = 8'd0;
                    if (Sync) begin
                        // Sync always restarts the frame; an early one drops the partial frame.
                        if (slot_q != 2'd0) begin
                            err_d = 1'b1;
                        end
                        sh0_d  = In;
                        slot_d = 2'd1;
                    end else begin
                        unique case (slot_q)
                            2'd0: begin
                                // Slot 0 without sync: lost alignment.
                                err_d   = 1'b1;
                                state_d = StHunt;
                            end
                            2'd1: begin
                                sh1_d  = In;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d  = In;
                                slot_d = 2'd3;
                            end
                            2'd3: begin
                                out_a_d       = sh0_q;
                                out_b_d       = sh1_q;
                                out_c_d       = sh2_q;
                                out_d_d       = In;
                                frame_valid_d = 1'b1;
                                slot_d        = 2'd0;
                            end
                            default: ;
                        endcase
                    end
                end else if (slot_q != 2'd0) begin
                    // Stall inside a frame; idles between frames are unlimited.
                    if (gap_inc == GapLim) begin
                        err_d   = 1'b1;
                        state_d = StHunt;
                        slot_d  = 2'd0;
                        gap_d   = 8'd0;
                    end else begin
                        gap_d = gap_inc[7:0];
                    end
                end else begin
                    gap_d = 8'd0;
                end
            end

            default: begin
                state_d = StHunt;
                slot_d  = 2'd0;
                gap_d   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StHunt;
            slot_q        <= 2'd0;
            gap_q         <= 8'd0;
            sh0_q         <= '0;
            sh1_q         <= '0;
            sh2_q         <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_c_q       <= '0;
            out_d_q       <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            gap_q         <= gap_d;
            sh0_q         <= sh0_d;
            sh1_q         <= sh1_d;
            sh2_q         <= sh2_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_c_q       <= out_c_d;
            out_d_q       <= out_d_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    assign OutA       = out_a_q;
    assign OutB       = out_b_q;
    assign OutC       = out_c_q;
    assign OutD       = out_d_q;
    assign FrameValid = frame_valid_q;
    assign Slot       = slot_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tdm_demux1_4_4bit.sv
// Bench for tdm_demux1_4_4bit: directed frames with hand-computed results, then
// a long random run compared against a behavioural model.
module tb_tdm_demux1_4_4bit;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned GAP   = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] In;
    logic             InValid;
    logic             Sync;
    logic [WIDTH-1:0] OutA, OutB, OutC, OutD;
    logic             FrameValid;
    logic [1:0]       Slot;
    logic             err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Behavioural model state.
    logic             m_run;
    logic [1:0]       m_slot;
    int unsigned      m_gap;
    logic [WIDTH-1:0] m_sh [3];
    logic [WIDTH-1:0] m_out [4];
    logic             m_fv;
    logic             m_err;

    tdm_demux1_4_4bit #(
        .WIDTH (WIDTH),
        .GAP   (GAP)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .In         (In),
        .InValid    (InValid),
        .Sync       (Sync),
        .OutA       (OutA),
        .OutB       (OutB),
        .OutC       (OutC),
        .OutD       (OutD),
        .FrameValid (FrameValid),
        .Slot       (Slot),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [WIDTH-1:0] d, input logic v,
                              input logic s);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_run  = 1'b0;
            m_slot = 2'd0;
            m_gap  = 0;
            for (int i = 0; i < 3; i++) m_sh[i] = '0;
            for (int i = 0; i < 4; i++) m_out[i] = '0;
        end else if (!m_run) begin
            if (v && s) begin
                m_sh[0] = d;
                m_slot  = 2'd1;
                m_run   = 1'b1;
            end
        end else if (v) begin
            m_gap = 0;
            if (s) begin
                if (m_slot != 2'd0) m_err = 1'b1;
                m_sh[0] = d;
                m_slot  = 2'd1;
            end else if (m_slot == 2'd0) begin
                m_err = 1'b1;
                m_run = 1'b0;
            end else if (m_slot == 2'd3) begin
                m_out[0] = m_sh[0];
                m_out[1] = m_sh[1];
                m_out[2] = m_sh[2];
                m_out[3] = d;
                m_fv     = 1'b1;
                m_slot   = 2'd0;
            end else begin
                m_sh[m_slot] = d;
                m_slot       = m_slot + 2'd1;
            end
        end else if (m_slot != 2'd0) begin
            m_gap++;
            if (m_gap == GAP) begin
                m_err  = 1'b1;
                m_run  = 1'b0;
                m_slot = 2'd0;
                m_gap  = 0;
            end
        end
    endtask

    // Apply one cycle of inputs; returns at the following negedge.
    task automatic drive(input logic r, input logic [WIDTH-1:0] d, input logic v, input logic s);
        rst     = r;
        In      = d;
        InValid = v;
        Sync    = s;
        model_step(r, d, v, s);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic word(input logic [WIDTH-1:0] d, input logic s);
        drive(1'b0, d, 1'b1, s);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic [15:0] exp);
        check(tag, {16'd0, OutA, OutB, OutC, OutD}, {16'd0, exp});
    endtask

    initial begin
        rst = 1'b1; In = '0; InValid = 1'b0; Sync = 1'b0;
        @(negedge clk);

        // Reset state.
        do_reset();
        check_outs("reset_outs", 16'h0000);
        check("reset_fv", 32'(FrameValid), 32'd0);
        check("reset_slot", 32'(Slot), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // Single frame 1,8,A,5.
        word(4'h1, 1'b1);
        word(4'h8, 1'b0);
        check("f1_slot2", 32'(Slot), 32'd2);
        word(4'hA, 1'b0);
        check("f1_fv_early", 32'(FrameValid), 32'd0);
        word(4'h5, 1'b0);
        check_outs("f1_outs", 16'h18A5);
        check("f1_fv", 32'(FrameValid), 32'd1);
        check("f1_err", 32'(err), 32'd0);
        check("f1_slot", 32'(Slot), 32'd0);
        idle();
        check("f1_fv_pulse", 32'(FrameValid), 32'd0);
        check_outs("f1_hold", 16'h18A5);

        // Back-to-back frames.
        do_reset();
        word(4'h1, 1'b1); word(4'h8, 1'b0); word(4'hA, 1'b0); word(4'h5, 1'b0);
        check("b2b_fv1", 32'(FrameValid), 32'd1);
        word(4'h3, 1'b1);
        check("b2b_gap1", 32'(FrameValid), 32'd0);
        word(4'hC, 1'b0);
        check("b2b_gap2", 32'(FrameValid), 32'd0);
        word(4'hF, 1'b0);
        check("b2b_gap3", 32'(FrameValid), 32'd0);
        word(4'h0, 1'b0);
        check("b2b_fv2", 32'(FrameValid), 32'd1);
        check_outs("b2b_outs", 16'h3CF0);

        // Early sync at slot 2.
        do_reset();
        word(4'h1, 1'b1); word(4'h8, 1'b0); word(4'hA, 1'b0); word(4'h5, 1'b0);
        word(4'h7, 1'b1); word(4'h2, 1'b0);
        word(4'h9, 1'b1);
        check("early_err", 32'(err), 32'd1);
        check("early_fv", 32'(FrameValid), 32'd0);
        check("early_slot", 32'(Slot), 32'd1);
        check_outs("early_hold", 16'h18A5);
        word(4'h4, 1'b0);
        check("early_err_pulse", 32'(err), 32'd0);
        word(4'h6, 1'b0); word(4'hB, 1'b0);
        check("early_fv2", 32'(FrameValid), 32'd1);
        check_outs("early_outs", 16'h946B);

        // Missing sync at slot 0 -> HUNT.
        word(4'h6, 1'b0);
        check("miss_err", 32'(err), 32'd1);
        check_outs("miss_hold", 16'h946B);
        word(4'h1, 1'b0);
        check("miss_ign1", 32'(err), 32'd0);
        word(4'h2, 1'b0);
        check("miss_ign2", 32'(err), 32'd0);
        check("miss_slot", 32'(Slot), 32'd0);
        word(4'h3, 1'b1);
        check("miss_resync", 32'(Slot), 32'd1);
        word(4'h4, 1'b0); word(4'h5, 1'b0); word(4'h6, 1'b0);
        check("miss_fv", 32'(FrameValid), 32'd1);
        check_outs("miss_outs", 16'h3456);

        // Timeout after GAP idle cycles mid-frame.
        word(4'h2, 1'b1); word(4'h3, 1'b0);
        for (int i = 1; i < 16; i++) idle();
        check("to_15_err", 32'(err), 32'd0);
        check("to_15_slot", 32'(Slot), 32'd2);
        idle();
        check("to_16_err", 32'(err), 32'd1);
        check("to_16_slot", 32'(Slot), 32'd0);
        check_outs("to_hold", 16'h3456);
        idle();
        check("to_err_pulse", 32'(err), 32'd0);
        word(4'h7, 1'b0);
        check("to_hunting", 32'(err), 32'd0);
        word(4'h2, 1'b1); word(4'h3, 1'b0);
        for (int i = 1; i <= 15; i++) idle();
        check("to_15b_err", 32'(err), 32'd0);
        word(4'h4, 1'b0); word(4'h5, 1'b0);
        check("to_fv", 32'(FrameValid), 32'd1);
        check_outs("to_outs", 16'h2345);

        // Idle between frames never times out.
        for (int i = 0; i < 40; i++) idle();
        check("between_err", 32'(err), 32'd0);
        check("between_slot", 32'(Slot), 32'd0);

        // Reset mid-frame with all inputs active.
        word(4'h1, 1'b1); word(4'h8, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 1'b1);
        check_outs("rstmid_outs", 16'h0000);
        check("rstmid_slot", 32'(Slot), 32'd0);
        check("rstmid_fv", 32'(FrameValid), 32'd0);
        check("rstmid_err", 32'(err), 32'd0);
        word(4'h5, 1'b0);
        check("rstmid_needsync", 32'(Slot), 32'd0);

        // Random run against the model.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 499) == 0), 4'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
            check("rand", {12'd0, OutA, OutB, OutC, OutD, FrameValid, Slot, err},
                  {12'd0, m_out[0], m_out[1], m_out[2], m_out[3], m_fv, m_slot, m_err});
            check("rand_excl", 32'(err & FrameValid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux1_4_4bit.md
Name: tdm_demux1_4_4bit

Overview:
- Receive-side counterpart of the 4:1 lane mux.
- Takes a time-division-multiplexed word stream (slot 0..3, with a frame sync on slot 0) and distributes it back into four registered output lanes A..D.
- Raises a one-cycle FrameValid when a complete 4-slot frame has been captured.
- Flags misaligned or stalled frames on err, then re-hunts for sync.

Parameters:
- WIDTH, 4, data width of the input stream and of each output lane.
- GAP, 16, consecutive idle (InValid low) cycles tolerated mid-frame before a timeout error; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- In  input  WIDTH  TDM data word.
- InValid  input  1  In carries a valid slot word this cycle.
- Sync  input  1  qualifies the current valid word as slot 0; ignored when InValid is low.
- OutA  output  WIDTH  slot 0 word of the last complete frame.
- OutB  output  WIDTH  slot 1 word of the last complete frame.
- OutC  output  WIDTH  slot 2 word of the last complete frame.
- OutD  output  WIDTH  slot 3 word of the last complete frame.
- FrameValid  output  1  one-cycle pulse: OutA..OutD updated this cycle.
- Slot  output  2  index of the next expected slot.
- err  output  1  one-cycle pulse: framing or timeout error.

Behaviour:
- Reset:
  - Applies on any rising edge with rst=1 and has priority over all other inputs.
  - State=HUNT, Slot=0, gap counter=0, shadow regs=0.
  - OutA..OutD=0, FrameValid=0, err=0.
- States: HUNT, RUN. Three WIDTH-bit shadow regs hold slots 0..2 of the frame in progress.
- HUNT:
  - Words with InValid=1 and Sync=0 are discarded; no err.
  - On InValid=1 and Sync=1: shadow0<=In, Slot<=1, go to RUN.
- RUN, valid word (InValid=1), gap counter cleared:
  - Sync=1 and Slot!=0 (early sync): err pulse, partial frame dropped, shadow0<=In, Slot<=1, stay in RUN (immediate resync).
  - Sync=0 and Slot=0 (missing sync): err pulse, word dropped, go to HUNT.
  - Sync=1 and Slot=0: shadow0<=In, Slot<=1.
  - Slot=1 or 2, Sync=0: shadow[Slot]<=In, Slot<=Slot+1.
  - Slot=3, Sync=0: frame completes on this edge:
    - OutA<=shadow0, OutB<=shadow1, OutC<=shadow2, OutD<=In.
    - FrameValid<=1 for exactly one cycle; Slot wraps to 0; stay in RUN.
- Frame latency: outputs and FrameValid are visible in the cycle after the edge that samples the slot-3 word.
- Output hold: OutA..OutD hold their values until the next complete frame. Errors, HUNT and timeouts never modify them; only reset clears them.
- Timeout, RUN with Slot!=0 and InValid=0:
  - The gap counter increments each such cycle.
  - When the count reaches GAP: err pulse, go to HUNT, Slot<=0, counter<=0.
  - In RUN with Slot=0 (between frames), idle cycles never time out and the counter stays 0.
- Back-to-back frames: slot-0-with-Sync may directly follow slot 3, so FrameValid can pulse every 4 cycles.
- err and FrameValid are never both high in the same cycle.
- Reset mid-frame: partial frame discarded, outputs cleared; the first post-reset frame requires a fresh Sync.

Test Plan:
- Reset, then 4 consecutive valid words 1,8,A,5 with Sync on the first -> one cycle after the 4th edge: OutA=1, OutB=8, OutC=A, OutD=5, FrameValid=1 for 1 cycle; err stays 0; Slot=0.
- Two back-to-back frames (1,8,A,5 then 3,C,F,0) with no idle cycles -> FrameValid pulses exactly 4 cycles apart; second frame gives OutA..D=3,C,F,0.
- Frame 1,8,A,5 completes, then words 7,2 with Sync on 7, then Sync on word 9 at Slot=2 -> err pulse on that edge; OutA..D stay 1,8,A,5; frame 9,4,6,B then completes with FrameValid.
- In RUN with Slot=0, word 6 without Sync -> err pulse, HUNT; following words without Sync are ignored with no further err; the next Sync word restarts capture.
- GAP=16: valid words 2,3 with Sync on 2, then InValid low for 16 cycles -> err pulses on the 16th idle cycle and the block returns to HUNT; 15 idle cycles followed by words 4,5 -> frame 2,3,4,5 completes normally.
- rst asserted at Slot=2 with In, InValid and Sync all active -> next cycle all outputs 0 and Slot=0. 10000 cycles of $random stimulus vs a behavioural model, checked on negedge clk -> no mismatch.
